// File: rtl/ye_word_packer_if.sv
// Symbol-in / packed-word-out bundle for ye_word_packer.
// slave is the packer side; master is the producer/consumer side driving it.
interface ye_word_packer_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned CNT_W  = 3
);
    logic [1:0]        sym_in;
    logic              sym_valid;
    logic              flush;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [CNT_W-1:0]  fifo_count;
    logic              overflow;

    modport slave (
        input  sym_in, sym_valid, flush, word_ready,
        output word_out, word_valid, fifo_count, overflow
    );

    modport master (
        output sym_in, sym_valid, flush, word_ready,
        input  word_out, word_valid, fifo_count, overflow
    );
endinterface

// File: rtl/ye_word_packer.sv
// Packs consecutive 2-bit ye symbols into words, LSB-first, and queues them in a small FIFO
// with a valid/ready output side, exact occupancy and a sticky overflow flag.
module ye_word_packer #(
    parameter int unsigned SYMS_PER_WORD = 4,
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    ye_word_packer_if.slave   bus
);
    localparam int unsigned WORD_W = 2 * SYMS_PER_WORD;
    localparam int unsigned PH_W   = $clog2(SYMS_PER_WORD);
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    logic [PH_W-1:0]   phase_q, phase_d;
    logic [WORD_W-1:0] pack_q, pack_d;
    logic [WORD_W-1:0] word_full;
    logic [WORD_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              complete, pop, full, push_ok;

    always_comb begin
        word_full = pack_q;
        for (int i = 0; i < SYMS_PER_WORD; i++) begin
            if (PH_W'(i) == phase_q) word_full[2*i +: 2] = bus.sym_in;
        end

        complete = bus.sym_valid && (phase_q == PH_W'(SYMS_PER_WORD - 1));
        pop      = (count_q != '0) && bus.word_ready;
        full     = (count_q == CNT_W'(DEPTH));
        // A pop on the same edge frees the head slot, so a full FIFO still takes the word.
        push_ok  = complete && (!full || pop);

        phase_d  = phase_q;
        pack_d   = pack_q;
        if (bus.sym_valid) begin
            if (complete) begin
                phase_d = '0;
                pack_d  = '0;
            end else begin
                phase_d = phase_q + PH_W'(1);
                pack_d  = word_full;
            end
        end

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop) count_d = count_q - CNT_W'(1);
        ovf_d    = ovf_q || (complete && !push_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (bus.flush) begin
            phase_q  <= '0;
            pack_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            pack_q   <= pack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: word_out is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && push_ok) mem[wr_ptr_q] <= word_full;
    end

    always_comb begin
        bus.word_valid = (count_q != '0);
        bus.word_out   = bus.word_valid ? mem[rd_ptr_q] : '0;
        bus.fifo_count = count_q;
        bus.overflow   = ovf_q;
    end
endmodule

// File: tb/tb_ye_word_packer.sv
// Directed self-checking bench for ye_word_packer at default parameters.
// Inputs change and outputs are sampled on the falling edge.
module tb_ye_word_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    ye_word_packer_if #(.WORD_W(8), .CNT_W(3)) bus ();

    ye_word_packer #(
        .SYMS_PER_WORD(4),
        .DEPTH        (4),
        .CNT_W        (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic send_sym(input logic [1:0] s, input logic rdy);
        bus.sym_in     = s;
        bus.sym_valid  = 1'b1;
        bus.word_ready = rdy;
        @(negedge clk);
        bus.sym_valid  = 1'b0;
        bus.word_ready = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int i = 0; i < 4; i++) send_sym(w[2*i +: 2], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pop_one();
        bus.word_ready = 1'b1;
        @(negedge clk);
        bus.word_ready = 1'b0;
    endtask

    logic [7:0] exp_q [4];
    logic [1:0] syms  [4];

    initial begin
        bus.sym_in     = 2'b00;
        bus.sym_valid  = 1'b0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b0;
        idle(2);
        check("rst_valid", 32'(bus.word_valid), 32'd0);
        check("rst_out",   32'(bus.word_out),   32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        check("rst_ovf",   32'(bus.overflow),   32'd0);
        rst = 1'b0;
        idle(1);

        // Basic pack: 10,11,01,00 -> 8'h1E
        syms = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) send_sym(syms[i], 1'b0);
        check("basic_valid_early", 32'(bus.word_valid), 32'd0);
        send_sym(syms[3], 1'b0);
        check("basic_valid", 32'(bus.word_valid), 32'd1);
        check("basic_out",   32'(bus.word_out),   32'h1E);
        check("basic_count", 32'(bus.fifo_count), 32'd1);
        check("basic_ovf",   32'(bus.overflow),   32'd0);
        pop_one();
        check("basic_drained", 32'(bus.word_valid), 32'd0);

        // Gapped input
        for (int i = 0; i < 3; i++) begin
            send_sym(syms[i], 1'b0);
            idle(3);
        end
        check("gap_valid_early", 32'(bus.word_valid), 32'd0);
        send_sym(syms[3], 1'b0);
        check("gap_out", 32'(bus.word_out), 32'h1E);
        pop_one();

        // Fill and overflow
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) push_word(exp_q[i]);
        check("full_count", 32'(bus.fifo_count), 32'd4);
        check("full_ovf",   32'(bus.overflow),   32'd0);
        push_word(8'h55);
        check("ovf_count", 32'(bus.fifo_count), 32'd4);
        check("ovf_flag",  32'(bus.overflow),   32'd1);
        check("ovf_head",  32'(bus.word_out),   32'h11);
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", 32'(bus.word_out), 32'(exp_q[i]));
            @(negedge clk);
        end
        bus.word_ready = 1'b0;
        check("ovf_empty_valid", 32'(bus.word_valid), 32'd0);
        check("ovf_empty_count", 32'(bus.fifo_count), 32'd0);
        check("ovf_sticky",      32'(bus.overflow),   32'd1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_clr_ovf", 32'(bus.overflow), 32'd0);

        // Simultaneous push/pop while full
        exp_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) push_word(exp_q[i]);
        send_sym(2'b01, 1'b0);
        send_sym(2'b01, 1'b0);
        send_sym(2'b11, 1'b0);
        send_sym(2'b10, 1'b1);  // completes 8'hB5 while popping 8'hA1
        check("pp_count", 32'(bus.fifo_count), 32'd4);
        check("pp_ovf",   32'(bus.overflow),   32'd0);
        exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_order", 32'(bus.word_out), 32'(exp_q[i]));
            @(negedge clk);
        end
        bus.word_ready = 1'b0;
        check("pp_empty", 32'(bus.word_valid), 32'd0);

        // Async reset mid-word with a word queued
        push_word(8'h77);
        send_sym(2'b11, 1'b0);
        send_sym(2'b11, 1'b0);
        check("mr_pre_valid", 32'(bus.word_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mr_valid", 32'(bus.word_valid), 32'd0);
        check("mr_out",   32'(bus.word_out),   32'd0);
        check("mr_count", 32'(bus.fifo_count), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) send_sym(2'b01, 1'b0);
        check("mr_word",  32'(bus.word_out),   32'h55);
        check("mr_count2", 32'(bus.fifo_count), 32'd1);
        pop_one();

        // Flush priority over sym_valid and word_ready
        push_word(8'h12);
        push_word(8'h34);
        for (int i = 0; i < 3; i++) send_sym(2'b10, 1'b0);
        bus.flush = 1'b1;
        send_sym(2'b11, 1'b1);
        bus.flush = 1'b0;
        check("fl_count", 32'(bus.fifo_count), 32'd0);
        check("fl_valid", 32'(bus.word_valid), 32'd0);
        check("fl_ovf",   32'(bus.overflow),   32'd0);
        send_sym(2'b00, 1'b0);
        send_sym(2'b01, 1'b0);
        send_sym(2'b10, 1'b0);
        check("fl_phase0", 32'(bus.word_valid), 32'd0);
        send_sym(2'b11, 1'b0);
        check("fl_word",  32'(bus.word_out),   32'hE4);
        check("fl_count2", 32'(bus.fifo_count), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ye_word_packer.md
Name: ye_word_packer

Overview:
- Downstream consumer of the 2-bit Mealy output symbol stream `ye`.
- Collects SYMS_PER_WORD consecutive valid symbols into one packed word.
- Buffers completed words in a small FIFO.
- Presents words to the next stage on a valid/ready handshake, with occupancy and a sticky overflow flag for debug.

Parameters:
- SYMS_PER_WORD, 4, symbols per packed word; word width WORD_W = 2*SYMS_PER_WORD; legal values 2..8.
- DEPTH, 4, FIFO entries; power of two, 2..16.
- CNT_W, 3, width of fifo_count; must hold DEPTH (log2(DEPTH)+1).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- sym_in  input  2  symbol from the Mealy stage (its `ye` output).
- sym_valid  input  1  sym_in is accepted on this edge.
- flush  input  1  synchronous clear of packer, FIFO and overflow.
- word_out  output  WORD_W  FIFO head word.
- word_valid  output  1  FIFO non-empty.
- word_ready  input  1  consumer accepts word_out this edge.
- fifo_count  output  CNT_W  number of words held, 0..DEPTH.
- overflow  output  1  sticky; a completed word was dropped.

Behaviour:
- Reset (async, rst=1): packer phase=0, packer register=0, FIFO pointers=0, fifo_count=0, word_valid=0, word_out=0, overflow=0. All outputs hold these values while rst is high.
- Packer:
  - Phase counter runs 0..SYMS_PER_WORD-1.
  - Each edge with sym_valid=1 stores sym_in at bits [2*phase+1 : 2*phase] and increments phase. The first symbol lands in the LSBs.
  - sym_valid=0: phase and register hold; gaps of any length are allowed.
  - On the edge accepting the symbol at phase SYMS_PER_WORD-1:
    - The completed word (register plus the current symbol) is pushed into the FIFO on that same edge.
    - Phase wraps to 0.
    - The packer register clears to 0.
- Latency: the completed word appears on word_out / word_valid one cycle after the completing edge, when the FIFO was empty.
- FIFO:
  - Pop occurs when word_valid=1 and word_ready=1 on an edge. word_ready with word_valid=0 has no effect.
  - word_out is always the oldest entry. word_out=0 when empty.
  - word_out and word_valid are stable while word_valid=1 and word_ready=0.
  - Push and pop on the same edge:
    - Always allowed, including when full.
    - fifo_count is unchanged.
    - Ordering is preserved.
  - Push when fifo_count=DEPTH and no pop that edge:
    - The word is dropped and FIFO contents are unchanged.
    - overflow is set to 1 and stays 1 until rst or flush.
  - Pointers wrap modulo DEPTH. fifo_count is the exact occupancy.
- Flush (synchronous):
  - Clears phase, packer register, FIFO and overflow on the next edge.
  - Takes priority over sym_valid and word_ready in the same cycle: the symbol is discarded and no pop is counted.
- rst asserted mid-word or mid-transfer: any partial word is lost. After release, the next SYMS_PER_WORD valid symbols form a fresh word.
- No combinational path from sym_in / sym_valid to any output. The only word_ready-to-output dependence is registered.

Test Plan:
- Basic pack (defaults):
  - Stimulus: after reset, sym_valid=1 for 4 cycles with sym_in=10,11,01,00; word_ready=0.
  - Response: one cycle after the 4th edge, word_valid=1, word_out=8'h1E, fifo_count=1, overflow=0.
- Gapped input:
  - Stimulus: same 4 symbols with sym_valid=0 for 3 cycles between each.
  - Response: word_out=8'h1E only after the 4th symbol; word_valid=0 before that.
- Full/overflow:
  - Stimulus: word_ready=0, push 5 words 8'h11,8'h22,8'h33,8'h44,8'h55.
  - Response: fifo_count=4, overflow=1 after the 5th word, word_out=8'h11. Then word_ready=1 for 4 cycles yields 11,22,33,44; then word_valid=0, fifo_count=0, overflow still 1.
- Simultaneous push/pop when full:
  - Stimulus: FIFO holds 4 words; word_ready=1 on the same edge a 5th word completes.
  - Response: fifo_count stays 4, overflow stays 0, the new word is last in order.
- Reset mid-word:
  - Stimulus: 2 symbols (11,11), async rst pulse between clock edges, then symbols 01,01,01,01.
  - Response: outputs zero immediately on rst; the next word is 8'h55, not a mix with the earlier symbols.
- Flush priority:
  - Stimulus: FIFO holds 2 words with phase=3; flush=1 with sym_valid=1 and word_ready=1 in the same cycle.
  - Response: next cycle fifo_count=0, word_valid=0, phase=0, overflow=0, and no word is emitted.
